// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared size/state codes, request record and byte helpers for mem_ctrl
package mem_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] MC_IDLE  = 2'd0;
  localparam logic [1:0] MC_READ  = 2'd1;
  localparam logic [1:0] MC_WRITE = 2'd2;

  localparam int RAM_ADDR_WIDTH_DEF = 17;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        iswrite;
  } mem_req_t;

  // Size code 11 is treated as a word access.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_req_latch.sv
// rtl/mem_req_latch.sv - one-deep pending request holder for a single mem_ctrl port
module mem_req_latch
  import mem_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     ena,
  input  logic     flush,
  input  logic     busy,
  input  logic     take,
  input  mem_req_t req_in,
  output logic     valid,
  output mem_req_t req
);

  logic     pend;
  logic     accept;
  mem_req_t held;

  // A pulse arriving while pending or in service is dropped, unless it
  // coincides with a flush, which replaces whatever was outstanding.
  always_comb begin
    accept = ena && (flush || (!pend && !busy));
    valid  = accept || (pend && !flush);
    req    = accept ? req_in : held;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      held <= '0;
    end else begin
      pend <= valid && !take;
      if (accept) held <= req_in;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates LSQ and fetch requests onto a byte-wide RAM, one byte per cycle
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_ls_ena,
  input  logic [DATA_WIDTH-1:0]     in_ls_addr,
  input  logic [DATA_WIDTH-1:0]     in_ls_data,
  input  logic                      in_ls_iswrite,
  input  logic [1:0]                in_ls_size,
  output logic                      out_ls_ready,
  output logic [DATA_WIDTH-1:0]     out_ls_data,
  input  logic                      in_if_ena,
  input  logic [DATA_WIDTH-1:0]     in_if_addr,
  input  logic                      in_if_flush,
  output logic                      out_if_ready,
  output logic [DATA_WIDTH-1:0]     out_if_data,
  input  logic [7:0]                ram_din,
  output logic [7:0]                ram_dout,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a,
  output logic                      ram_wr
);

  logic [1:0]                state;
  logic [2:0]                k;
  logic [2:0]                a_n;
  logic                      a_if;
  logic [RAM_ADDR_WIDTH-1:0] a_addr;
  logic [31:0]               a_data;
  logic [31:0]               acc;

  mem_req_t ls_in, if_in, ls_req, if_req, sel;
  logic     ls_valid, if_valid;
  logic     busy, abort, finishing, start_ls, start_if;
  logic [2:0] km1;
  logic     unused_bits;

  assign ls_in = '{addr: in_ls_addr, data: in_ls_data, size: in_ls_size, iswrite: in_ls_iswrite};
  assign if_in = '{addr: in_if_addr, data: 32'd0, size: SIZE_WORD, iswrite: 1'b0};

  mem_req_latch u_ls_latch (
    .clk    (clk),
    .rst    (rst),
    .ena    (in_ls_ena),
    .flush  (1'b0),
    .busy   (busy && !a_if),
    .take   (start_ls),
    .req_in (ls_in),
    .valid  (ls_valid),
    .req    (ls_req)
  );

  mem_req_latch u_if_latch (
    .clk    (clk),
    .rst    (rst),
    .ena    (in_if_ena),
    .flush  (in_if_flush),
    .busy   (busy && a_if),
    .take   (start_if),
    .req_in (if_in),
    .valid  (if_valid),
    .req    (if_req)
  );

  // A read spends n address cycles plus one capture cycle; the next access
  // may start on the edge that ends the last one, so there is no idle bubble.
  always_comb begin
    busy      = (state != MC_IDLE);
    abort     = (state == MC_READ) && a_if && in_if_flush;
    finishing = ((state == MC_READ) && (k == a_n) && !abort) ||
                ((state == MC_WRITE) && (k == a_n - 3'd1));
    start_ls  = ((state == MC_IDLE) || finishing) && ls_valid;
    start_if  = ((state == MC_IDLE) || finishing) && !ls_valid && if_valid;
    sel       = start_ls ? ls_req : if_req;
    km1       = k - 3'd1;
    ram_a     = '0;
    ram_wr    = 1'b0;
    ram_dout  = 8'd0;
    if (busy && (k < a_n)) begin
      ram_a = a_addr + RAM_ADDR_WIDTH'(k);
      if (state == MC_WRITE) begin
        ram_wr   = 1'b1;
        ram_dout = get_byte(a_data, k[1:0]);
      end
    end
  end

  assign unused_bits = ^{sel.addr[31:RAM_ADDR_WIDTH]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= MC_IDLE;
      k            <= 3'd0;
      a_n          <= 3'd0;
      a_if         <= 1'b0;
      a_addr       <= '0;
      a_data       <= 32'd0;
      acc          <= 32'd0;
      out_ls_ready <= 1'b0;
      out_ls_data  <= '0;
      out_if_ready <= 1'b0;
      out_if_data  <= '0;
    end else begin
      out_ls_ready <= 1'b0;
      out_ls_data  <= '0;
      out_if_ready <= 1'b0;
      out_if_data  <= '0;
      k <= busy ? k + 3'd1 : 3'd0;
      if ((state == MC_READ) && (k != 3'd0)) acc <= put_byte(acc, km1[1:0], ram_din);
      if (finishing) begin
        state <= MC_IDLE;
        k     <= 3'd0;
        if (state == MC_WRITE) begin
          out_ls_ready <= 1'b1;
        end else if (a_if) begin
          out_if_ready <= 1'b1;
          out_if_data  <= put_byte(acc, km1[1:0], ram_din);
        end else begin
          out_ls_ready <= 1'b1;
          out_ls_data  <= put_byte(acc, km1[1:0], ram_din);
        end
      end
      if (abort) begin
        state <= MC_IDLE;
        k     <= 3'd0;
      end
      if (start_ls || start_if) begin
        state  <= sel.iswrite ? MC_WRITE : MC_READ;
        k      <= 3'd0;
        a_if   <= start_if;
        a_addr <= sel.addr[RAM_ADDR_WIDTH-1:0];
        a_data <= sel.data;
        a_n    <= size_bytes(sel.size);
        acc    <= 32'd0;
      end
    end
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sits directly downstream of the load/store queue and the instruction-fetch unit; the only master of the byte-wide unified RAM.
- Latches single-cycle requests from both ports, arbitrates (LSQ first), and serialises each access into 1/2/4 little-endian byte transfers.
- Returns a one-cycle ready pulse with the assembled data.
- Sign extension is not done here; the LSQ applies it.

Parameters:
- DATA_WIDTH, 32, request address and data width.
- RAM_ADDR_WIDTH, 17, RAM address width; request addresses are truncated to these low bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_ls_ena  in  1  LSQ request pulse
- in_ls_addr  in  32  LSQ byte address
- in_ls_data  in  32  store data, low bytes used
- in_ls_iswrite  in  1  1 = store, 0 = load
- in_ls_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- out_ls_ready  out  1  LSQ done pulse
- out_ls_data  out  32  load data, zero-extended; 0 for stores
- in_if_ena  in  1  fetch request pulse; always a word read
- in_if_addr  in  32  fetch address
- in_if_flush  in  1  drop the pending or active fetch
- out_if_ready  out  1  fetch done pulse
- out_if_data  out  32  instruction word
- ram_din  in  8  RAM read byte, valid the cycle after its address
- ram_dout  out  8  RAM write byte
- ram_a  out  RAM_ADDR_WIDTH  RAM byte address
- ram_wr  out  1  1 = write this cycle

Behaviour:
- Reset (async, immediate): every output 0, state IDLE, both pending latches cleared, byte counter 0; any in-flight access is abandoned.
- Request latching:
  - Each port has one pending register, set on an ena pulse.
  - A pulse while that port is already pending or in service is a protocol violation and is ignored.
- State machine: IDLE, READ, WRITE.
  - IDLE: if LSQ pending, start it; else if fetch pending, start it; else outputs 0.
  - Starting is decided at the clock edge; the first byte's ram_a appears in the next cycle.
- Byte count: n = 1, 2 or 4 from size.
  - Byte k uses address (addr+k) truncated to RAM_ADDR_WIDTH; wraps at the top of RAM.
  - Byte k maps to data bits [8k+7:8k].
- READ:
  - ram_wr=0; ram_a = addr+k in cycles 0..n-1 of the access.
  - ram_din captured one cycle later into byte k.
  - Last byte is captured at the edge ending cycle n; the ready pulse is in cycle n+1.
  - Request in cycle T gives: ready at T+3 (byte), T+4 (half), T+6 (word).
- WRITE:
  - ram_wr=1 with ram_a/ram_dout for bytes k=0..n-1.
  - Ready pulse in the cycle after the last byte: request at T gives ready at T+2 (byte), T+5 (word).
  - out_ls_data = 0.
- Ready and data:
  - Ready is exactly one cycle; data is valid only in that cycle, otherwise 0.
  - In the ready cycle, the next pending access may already drive its first ram_a (back-to-back, no idle bubble).
  - ram_wr is 0 in any cycle not driving a write byte.
- Arbitration:
  - Non-preemptive; an active fetch always completes unless flushed.
  - Simultaneous ena pulses in IDLE: LSQ first, fetch follows immediately after.
- Flush:
  - in_if_flush clears the pending fetch.
  - If a fetch is active, it is aborted: IDLE next cycle, no out_if_ready, and the RAM may have seen extra read addresses (harmless).
  - A flush never affects LSQ traffic.
  - in_if_ena together with in_if_flush in the same cycle: the old fetch is dropped and the new request is latched.
- Stores are never aborted once started; the LSQ only issues committed stores.

Decomposition:
- constant.v gains:
  - size codes SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - state codes MC_IDLE/MC_READ/MC_WRITE;
  - RAM_ADDR_WIDTH default.
- One natural sub-module, mem_req_latch, instantiated per port: holds the pending flag, address, data, size and iswrite, and handles set/clear/flush.
- The FSM and byte sequencer stay in mem_ctrl.

Test Plan:
- RAM[0x100..0x103]=11 22 33 44; LSQ word load at 0x100, cycle T -> out_ls_ready at T+6, out_ls_data=0x44332211; ram_a=0x100..0x103 in T+1..T+4.
- LSQ byte store 0x1F0 data 0xDEADBEEF, size 00 -> one ram_wr cycle, ram_a=0x1F0, ram_dout=0xEF; ready at T+2; out_ls_data=0.
- LSQ half load and fetch word both pulsed at T (both at 0x200, RAM 0x200..0x203 = 0x80 0xFF 0x13 0x00) -> out_ls_ready T+4 with 0x0000FF80, not sign-extended; fetch ram_a starts T+4; out_if_ready T+9 with 0x0013FF80.
- Fetch at 0x0 at T, in_if_flush at T+2 -> no out_if_ready ever; IDLE at T+3; a new fetch at T+3 completes at T+9.
- rst asserted asynchronously mid word store after 2 bytes written -> all outputs 0 immediately, no ready pulse; only 2 bytes changed in RAM.
- Word load at address 0x1FFFF (RAM_ADDR_WIDTH 17) -> ram_a sequence 0x1FFFF, 0x00000, 0x00001, 0x00002.
